snoopy_bus_arbiter: RTL and testbench
=====================================

SNOOPY_BUS_ARBITER -- requirements
Module: snoopy_bus_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_OF_DEVICES, default 4, meaning the number of cache controllers sharing the snoopy bus (2..16).
REQ-002 SHALL have parameter MAX_TENURE, default 64, meaning the maximum number of cycles one device may hold the bus when the timeout feature is compiled in.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port request  input  NUMBER_OF_DEVICES  per-device bus request, level-held by each controller.
REQ-006 SHALL have port grant  output  NUMBER_OF_DEVICES  one-hot (or zero) bus grant.
REQ-007 SHALL have port busOwner  output  $clog2(NUMBER_OF_DEVICES)  index of the granted device, valid while busBusy=1.
REQ-008 SHALL have port busBusy  output  1  high while any grant is asserted.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a tenure is forcibly ended.

Function
REQ-010 SHALL implement states IDLE, GRANTED and TURNAROUND.
REQ-011 SHALL hold a round-robin pointer, PTR; in IDLE, it picks the first device with request=1 scanning PTR, PTR+1, ... modulo NUMBER_OF_DEVICES.
REQ-012 SHALL register the decision: request seen in IDLE at edge t gives grant, busOwner and busBusy at edge t+1, with state becoming GRANTED.
REQ-013 SHALL remain in IDLE with all outputs zero when request is all zero.
REQ-014 SHALL, in GRANTED, hold grant constant while request[busOwner]=1, ignoring all other request bits.
REQ-015 SHALL, in GRANTED, when request[busOwner]=0, deassert grant and busBusy at the next edge and enter TURNAROUND.
REQ-016 SHALL set PTR to (busOwner+1) mod NUMBER_OF_DEVICES on leaving GRANTED, wrapping from NUMBER_OF_DEVICES-1 to 0.
REQ-017 SHALL spend exactly one cycle in TURNAROUND with no grant, then return to IDLE; the minimum gap between two tenures is therefore 2 cycles without grant.
REQ-018 SHALL never assert more than one grant bit, and SHALL keep grant=0 outside GRANTED.
REQ-019 SHALL leave busOwner at its last value when busBusy=0.
REQ-020 SHALL, when several devices request simultaneously, grant only the first in round-robin order; the others wait, level-held, for later tenures.

Reset
REQ-021 SHALL, when reset=0 at a rising edge, force state IDLE, PTR=0, grant=0, busOwner=0, busBusy=0 and timeout=0, abandoning any tenure in progress.
REQ-022 SHALL, on the first edge with reset=1, begin normal arbitration; a request present then is granted one edge later.

Configuration
REQ-023 SHALL compile a tenure watchdog in when SNOOPY_BUS_ARBITER_TIMEOUT_EN is defined.
REQ-024 SHALL, with the macro defined, count GRANTED cycles from 1 at grant; when the count reaches MAX_TENURE with request[busOwner] still 1, it deasserts grant at the next edge, pulses timeout for that one cycle, and enters TURNAROUND with PTR advanced per REQ-016.
REQ-025 SHALL, without the macro, contain no counter, drive timeout constant 0 and hold grant indefinitely per REQ-014.

Verification
REQ-026 SHALL cover single requester: after reset, request=0001 -> grant=0001, busOwner=0, busBusy=1 one cycle later; drop request -> grant=0000 next cycle, grant again after 1 TURNAROUND cycle.
REQ-027 SHALL cover fairness: request=1111 held continuously for 40 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001 in that order, each released by its device after 3 cycles, with 2 no-grant cycles between tenures.
REQ-028 SHALL cover wrap-around: PTR=3 after device 2 releases, request=1001 -> grant=1000 first, then 0001.
REQ-029 SHALL cover reset mid-tenure: grant=0100 active, reset=0 for one edge -> all outputs 0 and PTR=0; with request=0110 still held, next grant is 0010.
REQ-030 SHALL cover timeout, macro defined with MAX_TENURE=8: request=0001 held -> grant held 8 cycles, then grant=0000 and timeout=1 for one cycle; without the macro, grant is still held at cycle 100 and timeout is never 1.

Source files
------------

// File: rtl/snoopy_bus_if.sv
// -----------------------------------------------------------------------------
// snoopy_bus_if
// Bus signals shared between the snoopy bus arbiter and the cache controllers.
//
// Parameter
//   NUMBER_OF_DEVICES : number of cache controllers on the bus (2..16)
//
// Signals
//   request  [N-1:0]        : per-device bus request, level-held by the controller
//   grant    [N-1:0]        : one-hot (or zero) bus grant
//   busOwner [clog2(N)-1:0] : index of the granted device, valid while busBusy=1
//   busBusy                 : high while any grant is asserted
//   timeout                 : one-cycle pulse when a tenure is forcibly ended
//
// Modports
//   master : arbiter side (drives grant/busOwner/busBusy/timeout)
//   slave  : controller side (drives request)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface snoopy_bus_if #(
  parameter int NUMBER_OF_DEVICES = 4
);
  localparam int OW = (NUMBER_OF_DEVICES > 1) ? $clog2(NUMBER_OF_DEVICES) : 1;

  logic [NUMBER_OF_DEVICES-1:0] request;
  logic [NUMBER_OF_DEVICES-1:0] grant;
  logic [OW-1:0]                busOwner;
  logic                         busBusy;
  logic                         timeout;

  modport master (
    input  request,
    output grant,
    output busOwner,
    output busBusy,
    output timeout
  );

  modport slave (
    output request,
    input  grant,
    input  busOwner,
    input  busBusy,
    input  timeout
  );
endinterface

// File: rtl/snoopy_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snoopy_bus_arbiter
// Round-robin arbiter for a snoopy bus shared by several cache controllers.
// A tenure starts one edge after a request is seen in IDLE, lasts while the
// owner keeps its request high, and is followed by one TURNAROUND cycle.
//
// Parameters
//   NUMBER_OF_DEVICES : number of cache controllers (2..16)
//   MAX_TENURE        : tenure limit in cycles when the watchdog is compiled in
//
// Ports
//   clock : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : snoopy_bus_if.master (request in; grant, busOwner, busBusy,
//           timeout out)
//
// Configuration
//   SNOOPY_BUS_ARBITER_TIMEOUT_EN : when defined, a tenure watchdog forcibly
//   ends any tenure that reaches MAX_TENURE cycles and pulses timeout. When
//   undefined there is no counter and timeout is tied low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module snoopy_bus_arbiter #(
  parameter int NUMBER_OF_DEVICES = 4,
  parameter int MAX_TENURE        = 64
) (
  input  logic         clock,
  input  logic         reset,
  snoopy_bus_if.master bus
);

  localparam int N  = NUMBER_OF_DEVICES;
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [N-1:0]  grant_r;
  logic [OW-1:0] owner_r;
  logic          busy_r;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;

  // Index following the current owner, wrapping at the last device.
  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
    if (idx == OW'(N - 1)) return '0;
    return idx + OW'(1);
  endfunction

  // One-hot vector for a device index.
  function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin scan: first requester found starting at ptr, modulo N.
  always_comb begin
    int j;
    logic [OW-1:0] idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = OW'(j);
      if (!pick_valid && bus.request[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(MAX_TENURE + 1);

  logic [CW-1:0] tenure_cnt;
  logic          timeout_r;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_r    <= '0;
      owner_r    <= '0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
      tenure_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout_r <= 1'b0;
          if (pick_valid) begin
            grant_r    <= onehot(pick_idx);
            owner_r    <= pick_idx;
            busy_r     <= 1'b1;
            tenure_cnt <= CW'(1);
            state      <= GRANTED;
          end
        end
        GRANTED: begin
          if (!bus.request[owner_r]) begin
            grant_r <= '0;
            busy_r  <= 1'b0;
            ptr     <= next_idx(owner_r);
            state   <= TURNAROUND;
          end else if (tenure_cnt == CW'(MAX_TENURE)) begin
            // Owner still requesting at the limit: end the tenure by force.
            grant_r   <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
            ptr       <= next_idx(owner_r);
            state     <= TURNAROUND;
          end else begin
            tenure_cnt <= tenure_cnt + CW'(1);
          end
        end
        TURNAROUND: begin
          timeout_r <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          grant_r   <= '0;
          busy_r    <= 1'b0;
          timeout_r <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.timeout = timeout_r;
`else
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_r <= '0;
      owner_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_r <= onehot(pick_idx);
            owner_r <= pick_idx;
            busy_r  <= 1'b1;
            state   <= GRANTED;
          end
        end
        GRANTED: begin
          // Other requesters are ignored until the owner lets go.
          if (!bus.request[owner_r]) begin
            grant_r <= '0;
            busy_r  <= 1'b0;
            ptr     <= next_idx(owner_r);
            state   <= TURNAROUND;
          end
        end
        TURNAROUND: begin
          state <= IDLE;
        end
        default: begin
          grant_r <= '0;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.timeout = 1'b0;
`endif

  assign bus.grant    = grant_r;
  assign bus.busOwner = owner_r;
  assign bus.busBusy  = busy_r;

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_snoopy_bus_arbiter
// Directed bench for snoopy_bus_arbiter with 4 devices. Inputs change and
// outputs are sampled on the falling clock edge. Each observation is the
// packed vector {grant[3:0], busOwner[1:0], busBusy, timeout}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_snoopy_bus_arbiter;

  localparam int N  = 4;
  localparam int MT = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  snoopy_bus_if #(.NUMBER_OF_DEVICES(N)) bif ();

  snoopy_bus_arbiter #(
    .NUMBER_OF_DEVICES(N),
    .MAX_TENURE       (MT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bif.master)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    reset = 1'b0;
    bif.request = 4'b1111;
    repeat (3) tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", obs, 8'b0000_00_0_0);
    end
    bif.request = '0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] obs;
    reset = 1'b0;
    bif.request = '0;
    repeat (2) tick();
    reset = 1'b1;
    bif.request = 4'b0001;
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_grant: got %b required %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_hold: got %b required %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    bif.request = 4'b0000;
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_release: got %b required %b", obs, {4'b0000, 2'd0, 1'b0, 1'b0});
    end
    bif.request = 4'b0001;
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_gap: got %b required %b", obs, {4'b0000, 2'd0, 1'b0, 1'b0});
    end
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_regrant: got %b required %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    bif.request = '0;
    repeat (3) tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5];
    logic [1:0] exp_o [5];
    logic [7:0] obs;
    logic [7:0] exp;
    exp_g[0] = 4'b0001; exp_o[0] = 2'd0;
    exp_g[1] = 4'b0010; exp_o[1] = 2'd1;
    exp_g[2] = 4'b0100; exp_o[2] = 2'd2;
    exp_g[3] = 4'b1000; exp_o[3] = 2'd3;
    exp_g[4] = 4'b0001; exp_o[4] = 2'd0;
    reset = 1'b0;
    bif.request = '0;
    repeat (2) tick();
    reset = 1'b1;
    bif.request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
        exp = {exp_g[k], exp_o[k], 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL fair_tenure%0d_cyc%0d: got %b required %b", k, c, obs, exp);
        end
      end
      // Owner lets go after its third granted cycle.
      bif.request = bif.request & ~exp_g[k];
      for (int c = 0; c < 2; c++) begin
        tick();
        obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
        exp = {4'b0000, exp_o[k], 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL fair_gap%0d_cyc%0d: got %b required %b", k, c, obs, exp);
        end
        bif.request = 4'b1111;
      end
    end
    bif.request = '0;
    repeat (4) tick();
  endtask

  task automatic test_wraparound();
    logic [7:0] obs;
    reset = 1'b0;
    bif.request = '0;
    repeat (2) tick();
    reset = 1'b1;
    bif.request = 4'b0100;
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_dev2: got %b required %b", obs, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
    bif.request = 4'b0000;
    tick();
    bif.request = 4'b1001;
    tick();
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_first_dev3: got %b required %b", obs, {4'b1000, 2'd3, 1'b1, 1'b0});
    end
    tick();
    bif.request = 4'b0001;
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_release_owner_kept: got %b required %b", obs, {4'b0000, 2'd3, 1'b0, 1'b0});
    end
    tick();
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_then_dev0: got %b required %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    bif.request = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_tenure();
    logic [7:0] obs;
    reset = 1'b0;
    bif.request = '0;
    repeat (2) tick();
    reset = 1'b1;
    // Device 1 tenure first so the pointer sits at 2 before the reset.
    bif.request = 4'b0010;
    tick();
    bif.request = 4'b0000;
    tick();
    bif.request = 4'b0100;
    tick();
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_grant_dev2: got %b required %b", obs, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
    bif.request = 4'b0110;
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_others_ignored: got %b required %b", obs, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
    reset = 1'b0;
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL midrst_outputs_cleared: got %b required %b", obs, 8'b0000_00_0_0);
    end
    reset = 1'b1;
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_ptr_cleared: got %b required %b", obs, {4'b0010, 2'd1, 1'b1, 1'b0});
    end
    bif.request = '0;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    logic [7:0] obs;
    reset = 1'b0;
    bif.request = '0;
    repeat (2) tick();
    reset = 1'b1;
    bif.request = 4'b0001;
`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
    for (int c = 1; c <= MT; c++) begin
      tick();
      obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
      n_checks++;
      if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL tmo_held_cyc%0d: got %b required %b", c, obs, {4'b0001, 2'd0, 1'b1, 1'b0});
      end
    end
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0000, 2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL tmo_pulse: got %b required %b", obs, {4'b0000, 2'd0, 1'b0, 1'b1});
    end
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL tmo_pulse_end: got %b required %b", obs, {4'b0000, 2'd0, 1'b0, 1'b0});
    end
    tick();
    obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
    n_checks++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL tmo_regrant: got %b required %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
`else
    for (int c = 1; c <= 100; c++) begin
      tick();
      obs = {bif.grant, bif.busOwner, bif.busBusy, bif.timeout};
      n_checks++;
      if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL notmo_held_cyc%0d: got %b required %b", c, obs, {4'b0001, 2'd0, 1'b1, 1'b0});
      end
    end
`endif
    bif.request = '0;
    repeat (3) tick();
  endtask

  initial begin
    bif.request = '0;
    test_reset();
    test_single();
    test_fairness();
    test_wraparound();
    test_reset_mid_tenure();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
